imem_loader: RTL and testbench

Program loader: the write side of the instruction memory that the single-cycle MIPS core fetches from. It accepts a length-prefixed byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes those words to consecutive instruction-memory addresses and holds the CPU in reset until the image is fully loaded. It sits between a byte source (UART RX or testbench) and the instruction memory write port.

---
 rtl/mips_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_word_packer.sv | 31 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types for the instruction-memory program loader.
// Provides loader_state_t and word/byte width constants.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE_S,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader.
// master: loader side; slave: byte source / memory side.
interface imem_loader_if;
  import mips_pkg::*;

  logic              BYTE_VALID;
  logic [BYTE_W-1:0] BYTE_DATA;
  logic              BYTE_READY;
  logic              IMEM_WE;
  logic [WORD_W-1:0] IMEM_ADDR;
  logic [WORD_W-1:0] IMEM_WDATA;

  modport master (
    input  BYTE_VALID,
    input  BYTE_DATA,
    output BYTE_READY,
    output IMEM_WE,
    output IMEM_ADDR,
    output IMEM_WDATA
  );

  modport slave (
    output BYTE_VALID,
    output BYTE_DATA,
    input  BYTE_READY,
    input  IMEM_WE,
    input  IMEM_ADDR,
    input  IMEM_WDATA
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs bytes big-endian into a word; word_full on 4th byte.
// Ports: clk, rst_n, clr, accept, data in; word, word_full out.
module word_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0] cnt;

  assign word_full = accept && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
    end else if (accept) begin
      cnt  <= cnt + 2'd1;
      word <= {word[WORD_W-BYTE_W-1:0], data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream loader into imem; holds CPU.
// Ports: CLK, RESET(n), START, bus(master), CPU_HOLD, DONE, ERROR.
// Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  imem_loader_if.master bus,
  output logic          CPU_HOLD,
  output logic          DONE,
  output logic          ERROR
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  loader_state_t     state, next;
  logic [7:0]        len_hi;
  logic [15:0]       words_left;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] word;
  logic              word_full;
  logic              accept;
  logic              start_go;
  logic [15:0]       len;
  logic              ready;

  assign ready = (state == LEN_HI) || (state == LEN_LO)
              || (state == DATA) || (state == CHECK);
  assign accept   = bus.BYTE_VALID && ready;
  assign start_go = START && ((state == IDLE)
                 || (state == DONE_S) || (state == ERR));
  assign len      = {len_hi, bus.BYTE_DATA};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      csum <= '0;
    else if (start_go)
      csum <= '0;
    else if (accept && state != CHECK)
      csum <= csum ^ bus.BYTE_DATA;
  end
`endif

  word_packer u_pack (
    .clk       (CLK),
    .rst_n     (RESET),
    .clr       (start_go),
    .accept    (accept && state == DATA),
    .data      (bus.BYTE_DATA),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE_S, ERR:
        if (START) next = LEN_HI;
      LEN_HI:
        if (accept) next = LEN_LO;
      LEN_LO:
        if (accept) begin
          if (len == 16'd0)
`ifdef LOADER_CHECKSUM_EN
            next = CHECK;
`else
            next = DONE_S;
`endif
          else if ({1'b0, len} > MAXW)
            next = ERR;
          else
            next = DATA;
        end
      DATA:
        if (word_full) next = WRITE;
      WRITE:
        if (words_left > 16'd1)
          next = DATA;
        else
`ifdef LOADER_CHECKSUM_EN
          next = CHECK;
`else
          next = DONE_S;
`endif
`ifdef LOADER_CHECKSUM_EN
      CHECK:
        if (accept)
          next = (bus.BYTE_DATA == csum) ? DONE_S : ERR;
`endif
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      len_hi     <= '0;
      words_left <= '0;
      addr       <= BASE_ADDR;
    end else begin
      state <= next;
      if (start_go)
        addr <= BASE_ADDR;
      if (state == LEN_HI && accept)
        len_hi <= bus.BYTE_DATA;
      if (state == LEN_LO && accept)
        words_left <= len;
      if (state == WRITE) begin
        addr       <= addr + 32'd4;
        words_left <= words_left - 16'd1;
      end
    end
  end

  assign bus.BYTE_READY = ready;
  assign bus.IMEM_WE    = (state == WRITE);
  assign bus.IMEM_ADDR  = addr;
  assign bus.IMEM_WDATA = word;
  assign CPU_HOLD       = (state != DONE_S);
  assign DONE           = (state == DONE_S);
  assign ERROR          = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (BASE_ADDR 0, MAX_WORDS 256).
// Checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold, done, err;

  imem_loader_if bus ();

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256)
  ) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .START    (start),
    .bus      (bus),
    .CPU_HOLD (hold),
    .DONE     (done),
    .ERROR    (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int we_twice = 0;
  int rdy_bad = 0;
  logic we_prev = 1'b0;
  logic [7:0] strm[$];

  always @(posedge clk) begin
    if (bus.IMEM_WE) begin
      wa.push_back(bus.IMEM_ADDR);
      wd.push_back(bus.IMEM_WDATA);
      if (we_prev) we_twice <= we_twice + 1;
      if (bus.BYTE_READY) rdy_bad <= rdy_bad + 1;
    end
    we_prev <= bus.IMEM_WE;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.BYTE_DATA  = b;
    bus.BYTE_VALID = 1'b1;
    while (!bus.BYTE_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.BYTE_READY)
      chk("ready_timeout", 32'(bus.BYTE_READY), 32'd1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.BYTE_VALID = 1'b0;
  endtask

  // rnd inserts idle gaps; inj pulses START before byte inj
  task automatic send_all(input bit rnd, input int inj);
    for (int i = 0; i < strm.size(); i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == inj) pulse_start();
      send_byte(strm[i]);
      if (i == 5) begin
        chk("w0_we", 32'(bus.IMEM_WE), 32'd1);
        chk("w0_rdy", 32'(bus.BYTE_READY), 32'd0);
        chk("w0_addr", bus.IMEM_ADDR, 32'h0);
        chk("w0_data", bus.IMEM_WDATA,
            {strm[2], strm[3], strm[4], strm[5]});
      end
    end
  endtask

  task automatic add_ck();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (strm[i]) x ^= strm[i];
    strm.push_back(x);
`endif
  endtask

  task automatic settle();
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk);
`endif
  endtask

  task automatic set_n2();
    strm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
             8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    add_ck();
  endtask

  task automatic check_load(input string tag);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'h0000_0000);
      chk({tag, "_d0"}, wd[0], 32'h2008_0005);
      chk({tag, "_a1"}, wa[1], 32'h0000_0004);
      chk({tag, "_d1"}, wd[1], 32'h2009_0007);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_we2"}, 32'(we_twice), 32'd0);
    chk({tag, "_rdyw"}, 32'(rdy_bad), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"}, 32'(bus.BYTE_READY), 32'd0);
    chk({tag, "_we"}, 32'(bus.IMEM_WE), 32'd0);
    chk({tag, "_addr"}, bus.IMEM_ADDR, 32'h0);
    chk({tag, "_wdata"}, bus.IMEM_WDATA, 32'h0);
    chk({tag, "_hold"}, 32'(hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    bus.BYTE_VALID = 1'b0;
    bus.BYTE_DATA  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // plain two-word load
    set_n2();
    wa.delete(); wd.delete();
    pulse_start();
    chk("st_rdy", 32'(bus.BYTE_READY), 32'd1);
    send_all(1'b0, -1);
    settle();
    check_load("n2");

    // oversize length rejected after LEN_LO
    pulse_start();
    chk("st_done_clr", 32'(done), 32'd0);
    wa.delete(); wd.delete();
    strm = '{8'h01, 8'h01};
    send_all(1'b0, -1);
    chk("big_err", 32'(err), 32'd1);
    chk("big_hold", 32'(hold), 32'd1);
    chk("big_rdy", 32'(bus.BYTE_READY), 32'd0);
    chk("big_nwr", 32'(wa.size()), 32'd0);
    pulse_start();
    chk("rec_rdy", 32'(bus.BYTE_READY), 32'd1);
    chk("rec_err", 32'(err), 32'd0);

    // zero-length image
    strm = '{8'h00, 8'h00};
    add_ck();
    send_all(1'b0, -1);
    chk("z_done", 32'(done), 32'd1);
    chk("z_nwr", 32'(wa.size()), 32'd0);

    // gapped stream with a stray START mid-data
    set_n2();
    wa.delete(); wd.delete();
    pulse_start();
    send_all(1'b1, 4);
    settle();
    check_load("rnd");

    // asynchronous reset after 3 data bytes
    set_n2();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(strm[i]);
    #2 rst_n = 1'b0;
    #1 check_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wa.delete(); wd.delete();
    pulse_start();
    send_all(1'b0, -1);
    settle();
    check_load("rst2");

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    wa.delete(); wd.delete();
    strm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_all(1'b0, -1);
    chk("ck_done", 32'(done), 32'd1);
    chk("ck_hold", 32'(hold), 32'd0);
    chk("ck_d0", (wd.size() == 1) ? wd[0] : 32'h0, 32'hDEAD_BEEF);
    pulse_start();
    strm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h24};
    send_all(1'b0, -1);
    chk("ckbad_err", 32'(err), 32'd1);
    chk("ckbad_hold", 32'(hold), 32'd1);
    chk("ckbad_done", 32'(done), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
